// File: rtl/axi_mm2s_pkg.sv
// ============================================================================
// Module : axi_mm2s_pkg
// Brief  : Shared state encoding, zero-length status code and command width.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axi_mm2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_ST = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic [7:0] ZLEN_STATUS = 8'h00;

    // Command word is {byte_count[15:0], address}.
    function automatic int cw_width(input int addr_w);
        return addr_w + 16;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_mm2s_rr_arbiter.sv
// ============================================================================
// Module : axi_mm2s_rr_arbiter
// Brief  : Round-robin winner search starting at rr_ptr; one-hot grant + index.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_mm2s_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [1:0]         rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [1:0]         idx_o
);

    logic [2:0] cand;
    logic       found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_i} + 3'(k);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (cand == 3'(i)) && valid_i[i]) begin
                    found      = 1'b1;
                    grant_o[i] = 1'b1;
                    idx_o      = 2'(i);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_mm2s_sched.sv
// ============================================================================
// Module : axi_mm2s_sched
// Brief  : Round-robin scheduler sharing one MM2S mover among C_NUM_REQ
//          requesters, one transfer outstanding. Optional macro
//          AXI_MM2S_SCHED_ZLEN_FILTER_EN answers zero-length commands locally.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_mm2s_sched
    import axi_mm2s_pkg::*;
#(
    parameter  int C_AXI_ADDR_WIDTH = 64,
    parameter  int C_NUM_REQ        = 2,
    localparam int CW               = cw_width(C_AXI_ADDR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [C_NUM_REQ*CW-1:0] s_axis_req_tdata,
    input  logic [C_NUM_REQ-1:0]    s_axis_req_tvalid,
    output logic [C_NUM_REQ-1:0]    s_axis_req_tready,
    output logic [C_NUM_REQ*8-1:0]  m_axis_rsp_tdata,
    output logic [C_NUM_REQ-1:0]    m_axis_rsp_tvalid,
    input  logic [C_NUM_REQ-1:0]    m_axis_rsp_tready,
    output logic [CW-1:0]           m_axis_ctl_tdata,
    output logic                    m_axis_ctl_tvalid,
    input  logic                    m_axis_ctl_tready,
    input  logic [7:0]              s_axis_st_tdata,
    input  logic                    s_axis_st_tvalid,
    output logic                    s_axis_st_tready,
    output logic [1:0]              owner,
    output logic                    busy
);

    state_t                   state_q, state_d;
    logic [1:0]               rr_ptr_q, rr_ptr_d;
    logic [1:0]               owner_q, owner_d;
    logic [CW-1:0]            ctl_data_q, ctl_data_d;
    logic [C_NUM_REQ*8-1:0]   rsp_data_q, rsp_data_d;

    logic [C_NUM_REQ-1:0]     arb_grant;
    logic [1:0]               arb_idx;
    logic                     arb_found;
    logic [CW-1:0]            sel_data;
    logic                     rsp_ready_own;

    axi_mm2s_rr_arbiter #(
        .NUM_REQ (C_NUM_REQ)
    ) u_arb (
        .valid_i  (s_axis_req_tvalid),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (arb_grant),
        .idx_o    (arb_idx)
    );

    assign arb_found = |arb_grant;

    always_comb begin
        sel_data      = '0;
        rsp_ready_own = 1'b0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (arb_idx == 2'(i)) begin
                sel_data = s_axis_req_tdata[i*CW +: CW];
            end
            if (owner_q == 2'(i)) begin
                rsp_ready_own = m_axis_rsp_tready[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            ctl_data_q <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            ctl_data_q <= ctl_data_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        ctl_data_d = ctl_data_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                // The one-hot ready always lands on a valid requester, so a winner means a handshake.
                if (arb_found) begin
                    owner_d    = arb_idx;
                    ctl_data_d = sel_data;
`ifdef AXI_MM2S_SCHED_ZLEN_FILTER_EN
                    if (sel_data[CW-1 -: 16] == 16'd0) begin
                        for (int i = 0; i < C_NUM_REQ; i++) begin
                            if (arb_idx == 2'(i)) begin
                                rsp_data_d[i*8 +: 8] = ZLEN_STATUS;
                            end
                        end
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                if (m_axis_ctl_tready) begin
                    state_d = ST_WAIT_ST;
                end
            end
            ST_WAIT_ST: begin
                if (s_axis_st_tvalid) begin
                    for (int i = 0; i < C_NUM_REQ; i++) begin
                        if (owner_q == 2'(i)) begin
                            rsp_data_d[i*8 +: 8] = s_axis_st_tdata;
                        end
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_own) begin
                    rr_ptr_d = (owner_q == 2'(C_NUM_REQ - 1)) ? 2'd0 : owner_q + 2'd1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is masked while rst_n is low so nothing looks accepted during reset.
    assign s_axis_req_tready = ((state_q == ST_IDLE) && rst_n) ? arb_grant : '0;
    assign m_axis_ctl_tvalid = (state_q == ST_ISSUE);
    assign m_axis_ctl_tdata  = ctl_data_q;
    assign s_axis_st_tready  = (state_q == ST_WAIT_ST);
    assign m_axis_rsp_tdata  = rsp_data_q;
    assign owner             = owner_q;
    assign busy              = (state_q != ST_IDLE);

    generate
        for (genvar g = 0; g < C_NUM_REQ; g++) begin : g_rsp_valid
            assign m_axis_rsp_tvalid[g] = (state_q == ST_RESP) && (owner_q == 2'(g));
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_axi_mm2s_sched.sv
// ============================================================================
// Module : tb_axi_mm2s_sched
// Brief  : Randomized scoreboard bench for axi_mm2s_sched with a mover model.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi_mm2s_sched;

    localparam int AW   = 64;
    localparam int NREQ = 2;
    localparam int CW   = AW + 16;

    localparam int PH_IDLE  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_RESP  = 3;

    typedef struct packed {
        logic [1:0] own;
        logic [7:0] st;
    } rsp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ*CW-1:0]    s_axis_req_tdata = '0;
    logic [NREQ-1:0]       s_axis_req_tvalid = '0;
    logic [NREQ-1:0]       s_axis_req_tready;
    logic [NREQ*8-1:0]     m_axis_rsp_tdata;
    logic [NREQ-1:0]       m_axis_rsp_tvalid;
    logic [NREQ-1:0]       m_axis_rsp_tready = '0;
    logic [CW-1:0]         m_axis_ctl_tdata;
    logic                  m_axis_ctl_tvalid;
    logic                  m_axis_ctl_tready = 1'b0;
    logic [7:0]            s_axis_st_tdata = '0;
    logic                  s_axis_st_tvalid = 1'b0;
    logic                  s_axis_st_tready;
    logic [1:0]            owner;
    logic                  busy;

    always #5 clk = ~clk;

    axi_mm2s_sched #(
        .C_AXI_ADDR_WIDTH (AW),
        .C_NUM_REQ        (NREQ)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_req_tdata  (s_axis_req_tdata),
        .s_axis_req_tvalid (s_axis_req_tvalid),
        .s_axis_req_tready (s_axis_req_tready),
        .m_axis_rsp_tdata  (m_axis_rsp_tdata),
        .m_axis_rsp_tvalid (m_axis_rsp_tvalid),
        .m_axis_rsp_tready (m_axis_rsp_tready),
        .m_axis_ctl_tdata  (m_axis_ctl_tdata),
        .m_axis_ctl_tvalid (m_axis_ctl_tvalid),
        .m_axis_ctl_tready (m_axis_ctl_tready),
        .s_axis_st_tdata   (s_axis_st_tdata),
        .s_axis_st_tvalid  (s_axis_st_tvalid),
        .s_axis_st_tready  (s_axis_st_tready),
        .owner             (owner),
        .busy              (busy)
    );

    int total = 0;
    int bad   = 0;

    // Stimulus knobs: percent probability per cycle.
    int p_valid = 100, p_ctl = 100, p_st = 100, p_rsp = 100, p_junk = 0;
    bit         st_fixed_en = 1'b0;
    logic [7:0] st_fixed    = 8'h00;

    logic [CW-1:0] cmd_q [NREQ][$];
    logic [7:0]    st_q[$];
    logic [CW-1:0] exp_ctl[$];
    rsp_t          exp_rsp[$];
    int            grant_log[$];

    int phase_m = PH_IDLE, ptr_m = 0, owner_m = 0, ctl_dut_hs = 0;
    logic [NREQ-1:0] req_hs = '0;
    bit ctl_hs = 1'b0, st_hs = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not seen, got timeout, expected event within bound", name);
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic logic [CW-1:0] mk(input logic [15:0] bc, input logic [AW-1:0] a);
        return {bc, a};
    endfunction

    // Monitor + reference model: decides at each falling edge what the next rising edge must do.
    always @(negedge clk) begin : mon
        int cur, w;
        logic [NREQ-1:0] exp_rdy, exp_rv;
        logic [CW-1:0] slot;
        rsp_t r;
        req_hs = '0;
        ctl_hs = 1'b0;
        st_hs  = 1'b0;
        if (m_axis_ctl_tvalid && m_axis_ctl_tready && rst_n) ctl_dut_hs++;
        if (!rst_n) begin
            chk("rst_req_tready", s_axis_req_tready, 0);
            chk("rst_ctl_tvalid", m_axis_ctl_tvalid, 0);
            chk("rst_st_tready", s_axis_st_tready, 0);
            chk("rst_rsp_tvalid", m_axis_rsp_tvalid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_owner", owner, 0);
            chk("rst_ctl_tdata", m_axis_ctl_tdata, 0);
            chk("rst_rsp_tdata", m_axis_rsp_tdata, 0);
            phase_m = PH_IDLE;
            ptr_m   = 0;
            owner_m = 0;
            exp_ctl.delete();
            exp_rsp.delete();
        end else begin
            cur     = phase_m;
            exp_rdy = '0;
            w       = -1;
            if (cur == PH_IDLE) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && s_axis_req_tvalid[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
                end
            end
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_tready", s_axis_req_tready, exp_rdy);
            chk("busy", busy, cur != PH_IDLE);
            if (cur != PH_IDLE) chk("owner", owner, owner_m);
            chk("ctl_tvalid", m_axis_ctl_tvalid, cur == PH_ISSUE);
            chk("st_tready", s_axis_st_tready, cur == PH_WAIT);
            exp_rv = '0;
            if (cur == PH_RESP && exp_rsp.size() > 0) exp_rv[exp_rsp[0].own] = 1'b1;
            chk("rsp_tvalid", m_axis_rsp_tvalid, exp_rv);
            req_hs = s_axis_req_tvalid & s_axis_req_tready;

            if (w >= 0) begin
                slot    = s_axis_req_tdata[w*CW +: CW];
                owner_m = w;
                grant_log.push_back(w);
`ifdef AXI_MM2S_SCHED_ZLEN_FILTER_EN
                if (slot[CW-1 -: 16] == 16'd0) begin
                    exp_rsp.push_back({2'(w), 8'h00});
                    phase_m = PH_RESP;
                end else begin
                    exp_ctl.push_back(slot);
                    phase_m = PH_ISSUE;
                end
`else
                exp_ctl.push_back(slot);
                phase_m = PH_ISSUE;
`endif
            end

            if (cur == PH_ISSUE) begin
                if (exp_ctl.size() == 0) begin
                    tmo("ctl_expected");
                end else begin
                    chk("ctl_tdata", m_axis_ctl_tdata, exp_ctl[0]);
                    if (m_axis_ctl_tready) begin
                        void'(exp_ctl.pop_front());
                        ctl_hs  = 1'b1;
                        phase_m = PH_WAIT;
                    end
                end
            end

            if (cur == PH_WAIT && s_axis_st_tvalid) begin
                exp_rsp.push_back({2'(owner_m), s_axis_st_tdata});
                st_hs   = 1'b1;
                phase_m = PH_RESP;
            end

            if (cur == PH_RESP) begin
                if (exp_rsp.size() == 0) begin
                    tmo("rsp_expected");
                end else begin
                    r = exp_rsp[0];
                    chk("rsp_tdata", m_axis_rsp_tdata[r.own*8 +: 8], r.st);
                    if (m_axis_rsp_tready[r.own]) begin
                        void'(exp_rsp.pop_front());
                        phase_m = PH_IDLE;
                        ptr_m   = (int'(r.own) + 1) % NREQ;
                    end
                end
            end
        end
    end

    // One cycle of stimulus: retire handshakes seen by the monitor, then drive new inputs.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (req_hs[i] && cmd_q[i].size() > 0) void'(cmd_q[i].pop_front());
        if (ctl_hs) st_q.push_back(st_fixed_en ? st_fixed : 8'($urandom));
        if (st_hs && st_q.size() > 0) void'(st_q.pop_front());
        for (int i = 0; i < NREQ; i++) begin
            s_axis_req_tvalid[i] = (cmd_q[i].size() > 0) && pct(p_valid);
            s_axis_req_tdata[i*CW +: CW] = (cmd_q[i].size() > 0) ? cmd_q[i][0] : {$urandom, $urandom, $urandom};
        end
        m_axis_ctl_tready = pct(p_ctl);
        if (st_q.size() > 0) begin
            s_axis_st_tvalid = pct(p_st);
            s_axis_st_tdata  = st_q[0];
        end else begin
            s_axis_st_tvalid = pct(p_junk);
            s_axis_st_tdata  = 8'($urandom);
        end
        for (int i = 0; i < NREQ; i++) m_axis_rsp_tready[i] = pct(p_rsp);
    endtask

    function automatic bit pending();
        bit any = 1'b0;
        for (int i = 0; i < NREQ; i++) if (cmd_q[i].size() > 0) any = 1'b1;
        return any || (phase_m != PH_IDLE);
    endfunction

    task automatic wait_idle(input int maxc);
        int c = 0;
        while (pending() && c < maxc) begin
            step();
            c++;
        end
        if (pending()) tmo("wait_idle");
    endtask

    initial begin : main
        int c, acc0;
        logic [CW-1:0] cmd;

        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Fairness: both requesters continuously valid.
        for (int n = 0; n < 2; n++) begin
            cmd_q[0].push_back(mk(16'(32 + n), 64'h100 + 64'(n)));
            cmd_q[1].push_back(mk(16'(48 + n), 64'h200 + 64'(n)));
        end
        wait_idle(200);
        chk("fair_count", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("fair_order", grant_log[i], i % 2);
        end

        // Basic transfer from requester 0 with status 0x01.
        st_fixed_en = 1'b1;
        st_fixed    = 8'h01;
        cmd = mk(16'd64, 64'h1000);
        cmd_q[0].push_back(cmd);
        c = 0;
        while (!m_axis_ctl_tvalid && c < 20) begin step(); c++; end
        if (m_axis_ctl_tvalid) chk("basic_ctl_tdata", m_axis_ctl_tdata, cmd); else tmo("basic_ctl");
        c = 0;
        while (!m_axis_rsp_tvalid[0] && c < 20) begin step(); c++; end
        if (m_axis_rsp_tvalid[0]) begin
            chk("basic_rsp_tdata", m_axis_rsp_tdata[7:0], 8'h01);
            chk("basic_rsp_tvalid", m_axis_rsp_tvalid, 2'b01);
            chk("basic_owner", owner, 0);
        end else tmo("basic_rsp");
        wait_idle(50);
        st_fixed_en = 1'b0;

        // Control stream back-pressure for 5 cycles.
        p_ctl = 0;
        acc0  = ctl_dut_hs;
        cmd   = mk(16'd200, 64'hDEAD_BEEF_0000_0040);
        cmd_q[1].push_back(cmd);
        c = 0;
        while (!m_axis_ctl_tvalid && c < 20) begin step(); c++; end
        if (!m_axis_ctl_tvalid) tmo("stall_ctl");
        for (int i = 0; i < 5; i++) begin
            chk("stall_tvalid", m_axis_ctl_tvalid, 1);
            chk("stall_tdata", m_axis_ctl_tdata, cmd);
            step();
        end
        p_ctl = 100;
        wait_idle(50);
        chk("stall_one_cmd", ctl_dut_hs - acc0, 1);

        // Response back-pressure on requester 1.
        p_rsp = 0;
        cmd_q[1].push_back(mk(16'd16, 64'h3000));
        c = 0;
        while (!m_axis_rsp_tvalid[1] && c < 20) begin step(); c++; end
        if (!m_axis_rsp_tvalid[1]) tmo("rsp_stall_wait");
        cmd_q[0].push_back(mk(16'd8, 64'h4000));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rsp_stall_busy", busy, 1);
            chk("rsp_stall_no_grant", s_axis_req_tready, 0);
            chk("rsp_stall_tvalid", m_axis_rsp_tvalid, 2'b10);
        end
        p_rsp = 100;
        step();
        step();
        chk("rsp_release_idle", busy, 0);
        wait_idle(50);

        // Reset asserted while waiting for mover status.
        p_st = 0;
        cmd_q[0].push_back(mk(16'd128, 64'h5000));
        c = 0;
        while (!s_axis_st_tready && c < 20) begin step(); c++; end
        if (!s_axis_st_tready) tmo("reset_wait_st");
        rst_n = 1'b0;
        #1;
        chk("rst_now_busy", busy, 0);
        chk("rst_now_st_tready", s_axis_st_tready, 0);
        chk("rst_now_ctl_tvalid", m_axis_ctl_tvalid, 0);
        chk("rst_now_rsp_tvalid", m_axis_rsp_tvalid, 0);
        for (int i = 0; i < NREQ; i++) cmd_q[i].delete();
        st_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        p_st  = 100;
        grant_log.delete();
        cmd_q[0].push_back(mk(16'd4, 64'h6000));
        cmd_q[1].push_back(mk(16'd4, 64'h7000));
        wait_idle(100);
        if (grant_log.size() > 0) chk("post_reset_first_grant", grant_log[0], 0);
        else tmo("post_reset_grant");

`ifdef AXI_MM2S_SCHED_ZLEN_FILTER_EN
        // Zero-length command answered without touching the mover.
        cmd_q[1].push_back(mk(16'd0, 64'h8000));
        c = 0;
        while (!m_axis_rsp_tvalid[1] && c < 20) begin
            step();
            chk("zlen_no_ctl", m_axis_ctl_tvalid, 0);
            c++;
        end
        if (m_axis_rsp_tvalid[1]) chk("zlen_status", m_axis_rsp_tdata[15:8], 8'h00);
        else tmo("zlen_rsp");
        wait_idle(50);
`endif

        // Randomized traffic with stray status beats and random back-pressure.
        p_valid = 70; p_ctl = 60; p_st = 60; p_rsp = 60; p_junk = 25;
        for (int i = 0; i < NREQ; i++) begin
            for (int n = 0; n < 25; n++) begin
                cmd_q[i].push_back(mk(($urandom_range(5) == 0) ? 16'd0 : 16'($urandom),
                                      {$urandom, $urandom}));
            end
        end
        wait_idle(20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
